hazard_stall_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_cmp.sv | 16 +
 rtl/hazard_stall_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_stall_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/stall control unit: FSM encoding, default
// register-index width and the hardwired-zero register index.
package hazard_pkg;

   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned X0_IDX         = 0;

   typedef enum logic {
      HS_IDLE   = 1'b0,
      HS_LSTALL = 1'b1
   } hs_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Source-vs-destination register compare for one operand, masked by the
// operand's use bit and by x0 (which never carries a dependency).
module hazard_cmp
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  rs_used,
   input  logic [REG_ADDR_W-1:0] rd,
   output logic                  match
);

   assign match = rs_used && (rs == rd) && (rd != REG_ADDR_W'(X0_IDX));

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, memory freeze and branch flush control beside the ID stage.
// Optional event counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  mem_ready,
   input  logic                  branch_taken,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  pipe_en,
   output logic                  stall
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           freeze_cycles,
   output logic [31:0]           flush_count
`endif
);

   hs_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rs1_match, rs2_match, haz, stall_req;

   hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs1 (
      .rs      (id_rs1),
      .rs_used (id_rs1_used),
      .rd      (ex_rd),
      .match   (rs1_match)
   );

   hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs2 (
      .rs      (id_rs2),
      .rs_used (id_rs2_used),
      .rd      (ex_rd),
      .match   (rs2_match)
   );

   assign haz       = ex_mem_read && (rs1_match || rs2_match);
   assign stall_req = haz || (state_q == HS_LSTALL);

   // Outputs follow reset immediately, so rst_n is part of the decode.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_en     = 1'b1;
      stall       = 1'b0;
      if (!rst_n) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         pipe_en     = 1'b0;
         idex_bubble = 1'b1;
         stall       = 1'b1;
      end else if (!mem_ready) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         pipe_en = 1'b0;
         stall   = 1'b1;
      end else if (branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall_req) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
         stall       = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (mem_ready) begin
         if (branch_taken) begin
            // The hazard belongs to a wrong-path instruction.
            state_d = HS_IDLE;
            cnt_d   = '0;
         end else begin
            unique case (state_q)
               HS_IDLE: begin
                  if (haz && (LOAD_LAT > 1)) begin
                     state_d = HS_LSTALL;
                     cnt_d   = CNT_W'(LOAD_LAT - 1);
                  end
               end
               HS_LSTALL: begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = HS_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
               default: begin
                  state_d = HS_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HS_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles_q, freeze_cycles_q, flush_count_q;
   logic        stall_ev, freeze_ev, flush_ev;

   assign freeze_ev = !mem_ready;
   assign flush_ev  = mem_ready && branch_taken;
   assign stall_ev  = mem_ready && !branch_taken && stall_req;

   // Saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q  <= '0;
         freeze_cycles_q <= '0;
         flush_count_q   <= '0;
      end else begin
         if (stall_ev && (stall_cycles_q != '1))   stall_cycles_q  <= stall_cycles_q + 32'd1;
         if (freeze_ev && (freeze_cycles_q != '1)) freeze_cycles_q <= freeze_cycles_q + 32'd1;
         if (flush_ev && (flush_count_q != '1))    flush_count_q   <= flush_count_q + 32'd1;
      end
   end

   assign stall_cycles  = stall_cycles_q;
   assign freeze_cycles = freeze_cycles_q;
   assign flush_count   = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus
// stream; outputs are checked mid-cycle against hand-computed control codes.
module tb_hazard_stall_unit;

   // Output code order: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en, stall}
   localparam logic [5:0] NORM = 6'b110010;
   localparam logic [5:0] STL  = 6'b000111;
   localparam logic [5:0] FRZ  = 6'b000001;
   localparam logic [5:0] FLS  = 6'b111110;
   localparam logic [5:0] RST  = 6'b000101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_mem_read, mem_ready, branch_taken;
   logic       pc_en1, ifid_en1, ifid_flush1, idex_bubble1, pipe_en1, stall1;
   logic       pc_en3, ifid_en3, ifid_flush3, idex_bubble3, pipe_en3, stall3;

   int n_checks = 0;
   int n_errors = 0;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stc1, frc1, flc1, stc3, frc3, flc3;
   logic [31:0] m_st1, m_fr1, m_fl1, m_st3, m_fr3, m_fl3;
`endif

   always #5 clk = ~clk;

   hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(4)) u_dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .pc_en        (pc_en1),
      .ifid_en      (ifid_en1),
      .ifid_flush   (ifid_flush1),
      .idex_bubble  (idex_bubble1),
      .pipe_en      (pipe_en1),
      .stall        (stall1)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cycles  (stc1),
      .freeze_cycles (frc1),
      .flush_count   (flc1)
`endif
   );

   hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) u_dut3 (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .pc_en        (pc_en3),
      .ifid_en      (ifid_en3),
      .ifid_flush   (ifid_flush3),
      .idex_bubble  (idex_bubble3),
      .pipe_en      (pipe_en3),
      .stall        (stall3)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stall_cycles  (stc3),
      .freeze_cycles (frc3),
      .flush_count   (flc3)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic rdy, input logic br);
      id_rs1       = rs1;
      id_rs1_used  = u1;
      id_rs2       = rs2;
      id_rs2_used  = u2;
      ex_rd        = rd;
      ex_mem_read  = mr;
      mem_ready    = rdy;
      branch_taken = br;
   endtask

   // Check both instances mid-cycle, then advance past the next rising edge.
   task automatic step(input string tag, input logic [5:0] e1, input logic [5:0] e3);
      @(negedge clk);
      check({tag, "/lat1"}, {26'd0, pc_en1, ifid_en1, ifid_flush1, idex_bubble1, pipe_en1,
            stall1}, {26'd0, e1});
      check({tag, "/lat3"}, {26'd0, pc_en3, ifid_en3, ifid_flush3, idex_bubble3, pipe_en3,
            stall3}, {26'd0, e3});
`ifdef HAZ_PERF_CNT_EN
      check({tag, "/st1"}, stc1, m_st1);
      check({tag, "/fr1"}, frc1, m_fr1);
      check({tag, "/fl1"}, flc1, m_fl1);
      check({tag, "/st3"}, stc3, m_st3);
      check({tag, "/fr3"}, frc3, m_fr3);
      check({tag, "/fl3"}, flc3, m_fl3);
      if (e1 == STL) m_st1++;
      if (e1 == FRZ) m_fr1++;
      if (e1 == FLS) m_fl1++;
      if (e3 == STL) m_st3++;
      if (e3 == FRZ) m_fr3++;
      if (e3 == FLS) m_fl3++;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
`ifdef HAZ_PERF_CNT_EN
      m_st1 = 0; m_fr1 = 0; m_fl1 = 0;
      m_st3 = 0; m_fr3 = 0; m_fl3 = 0;
`endif
   endtask

   initial begin
      clear_model();
      rst_n = 1'b0;
      drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
      #2;
      @(negedge clk);
      check("reset/lat1", {26'd0, pc_en1, ifid_en1, ifid_flush1, idex_bubble1, pipe_en1,
            stall1}, {26'd0, RST});
      check("reset/lat3", {26'd0, pc_en3, ifid_en3, ifid_flush3, idex_bubble3, pipe_en3,
            stall3}, {26'd0, RST});
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("idle", NORM, NORM);

      // Load x5 in EX, ID reads rs2=x5.
      drive(5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      step("rs2haz_c1", STL, STL);
      drive(5'd1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
      step("rs2haz_c2", NORM, STL);
      step("rs2haz_c3", NORM, STL);
      step("rs2haz_c4", NORM, NORM);

      // x0 never hazards; unused rs1 never hazards.
      drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
      step("x0", NORM, NORM);
      drive(5'd7, 1'b0, 5'd8, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
      step("rs1_unused", NORM, NORM);

      // Load x7, ID reads rs1=x7; freeze two cycles during stall cycle 2.
      drive(5'd7, 1'b1, 5'd8, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      step("frz_c1", STL, STL);
      drive(5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("frz_f1", FRZ, FRZ);
      step("frz_f2", FRZ, FRZ);
      drive(5'd7, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("frz_c2", NORM, STL);
      step("frz_c3", NORM, STL);
      step("frz_done", NORM, NORM);

      // Branch taken in the same cycle as a hazard cancels the stall.
      drive(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
      step("br_haz", FLS, FLS);
      drive(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("br_after", NORM, NORM);

      // Back-to-back: new hazard on the cycle right after LSTALL ends.
      drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      step("b2b_c1", STL, STL);
      drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("b2b_c2", NORM, STL);
      step("b2b_c3", NORM, STL);
      drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      step("b2b_c4", STL, STL);
      drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("b2b_c5", NORM, STL);
      step("b2b_c6", NORM, STL);
      step("b2b_c7", NORM, NORM);

      // Reset asserted in the middle of LSTALL.
      drive(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      step("rst_mid_c1", STL, STL);
      drive(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      clear_model();
      #1;
      check("rst_mid/lat3", {26'd0, pc_en3, ifid_en3, ifid_flush3, idex_bubble3, pipe_en3,
            stall3}, {26'd0, RST});
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("rst_resume", NORM, NORM);
      drive(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      step("rst_fresh_c1", STL, STL);
      drive(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("rst_fresh_c2", NORM, STL);
      step("rst_fresh_c3", NORM, STL);
      step("rst_fresh_c4", NORM, NORM);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
